// File: rtl/pipeline_pkg.sv
// Shared definitions for the in-order pipeline: fetch state encoding, IF/ID
// register layout and the architectural constants the front end depends on.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // An IF/ID bubble keeps the old pc4; only instr and valid are cleared.
    function automatic ifid_t make_bubble(input ifid_t cur);
        ifid_t b;
        b       = cur;
        b.instr = NOP;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/adder.sv
// Plain W-bit adder; the carry out is dropped so sums wrap modulo 2^W.
module adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/mux.sv
// Two-input W-bit multiplexer: sel=1 picks d1.
module mux #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a request/ack instruction memory, absorbs ID
// stalls in a one-word hold buffer and squashes in-flight fetches on redirects.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_buf_q, hold_buf_d;
    logic [31:0]  saved_target_q, saved_target_d;
    ifid_t        ifid_q, ifid_d;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic [31:0]  pc_plus4;

    // A stalled ID stage cannot accept a redirect; it is re-presented later.
    assign redirect = (pc_src | jump) & ~stall;

    mux #(32) u_target_mux (
        .sel (pc_src),
        .d0  (jump_target),
        .d1  (branch_target),
        .y   (redirect_target)
    );

    adder #(32) u_pc_adder (
        .a (pc_q),
        .b (PC_INCR),
        .y (pc_plus4)
    );

    // NOTE: every state bit, including the hold buffer and saved target, is
    // reset so a post-reset HOLD/DROP can never replay stale contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= FS_IDLE;
            pc_q           <= RESET_PC;
            hold_buf_q     <= NOP;
            saved_target_q <= 32'h0;
            ifid_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments make all flops sample together.
            state_q        <= state_d;
            pc_q           <= pc_d;
            hold_buf_q     <= hold_buf_d;
            saved_target_q <= saved_target_d;
            ifid_q         <= ifid_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_d = state_q;
        unique case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                if (imem_ack) begin
                    if (!redirect && stall) state_d = FS_HOLD;
                end else if (redirect) begin
                    state_d = FS_DROP;
                end
            end
            FS_DROP: if (imem_ack) state_d = FS_REQ;
            FS_HOLD: if (!stall) state_d = FS_REQ;
            default: state_d = FS_IDLE;
        endcase
    end

    always_comb begin
        pc_d           = pc_q;
        hold_buf_d     = hold_buf_q;
        saved_target_d = saved_target_q;
        ifid_d         = ifid_q;
        unique case (state_q)
            FS_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d   = redirect_target;
                        ifid_d = make_bubble(ifid_q);
                    end else if (stall) begin
                        hold_buf_d = imem_rdata;
                    end else begin
                        ifid_d = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
                        pc_d   = pc_plus4;
                    end
                end else if (redirect) begin
                    saved_target_d = redirect_target;
                    ifid_d         = make_bubble(ifid_q);
                end else if (!stall) begin
                    ifid_d = make_bubble(ifid_q);
                end
            end
            FS_DROP: begin
                // The address must stay put until the orphaned request is acked.
                if (redirect) saved_target_d = redirect_target;
                if (!stall)   ifid_d = make_bubble(ifid_q);
                if (imem_ack) pc_d = redirect ? redirect_target : saved_target_q;
            end
            FS_HOLD: begin
                if (redirect) begin
                    pc_d   = redirect_target;
                    ifid_d = make_bubble(ifid_q);
                end else if (!stall) begin
                    ifid_d = '{instr: hold_buf_q, pc4: pc_plus4, valid: 1'b1};
                    pc_d   = pc_plus4;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == FS_REQ) || (state_q == FS_DROP);
        imem_addr  = pc_q;
        ifid_instr = ifid_q.instr;
        ifid_pc4   = ifid_q.pc4;
        ifid_valid = ifid_q.valid;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, pc_src, jump, imem_ack;
    logic [31:0] branch_target, jump_target, imem_rdata;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, ifid_instr, ifid_pc4;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid)
    );

    always #5 clock = ~clock;

    // Reference model: a fetch address, a flag saying the outstanding request
    // is to be thrown away (and where to go afterwards), and a queue holding a
    // fetched word that ID could not yet accept.
    logic        m_started;
    logic [31:0] m_pc;
    logic        m_kill;
    logic [31:0] m_kill_tgt;
    logic [31:0] m_buf[$];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_pc      = RST_PC;
        m_kill    = 1'b0;
        m_buf.delete();
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
    endtask

    task automatic bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] w);
        m_instr = w;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic model_step(input logic s, input logic ps, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic a,
                              input logic [31:0] w);
        logic        red;
        logic [31:0] tgt;
        red = (ps | j) & ~s;
        tgt = ps ? bt : jt;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_buf.size() != 0) begin
            if (red) begin
                m_buf.delete();
                m_pc = tgt;
                bubble();
            end else if (!s) begin
                deliver(m_buf.pop_front());
            end
        end else if (m_kill) begin
            if (red) m_kill_tgt = tgt;
            if (!s)  bubble();
            if (a) begin
                m_pc   = m_kill_tgt;
                m_kill = 1'b0;
            end
        end else if (a) begin
            if (red)    begin m_pc = tgt; bubble(); end
            else if (s) m_buf.push_back(w);
            else        deliver(w);
        end else if (red) begin
            m_kill     = 1'b1;
            m_kill_tgt = tgt;
            bubble();
        end else if (!s) begin
            bubble();
        end
    endtask

    task automatic compare_model();
        check("imem_req",   {31'h0, imem_req},   {31'h0, m_started && m_buf.size() == 0});
        check("imem_addr",  imem_addr,           m_pc);
        check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
        check("ifid_instr", ifid_instr,          m_instr);
        if (m_valid) check("ifid_pc4", ifid_pc4, m_pc4);
    endtask

    // Called at a falling edge: check, drive one cycle of inputs, advance model.
    task automatic step(input logic s, input logic ps, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic a);
        compare_model();
        stall         = s;
        pc_src        = ps;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        imem_ack      = a;
        imem_rdata    = a ? mem_word(m_pc) : 32'hDEAD_BEEF;
        model_step(s, ps, bt, j, jt, a, mem_word(m_pc));
        @(negedge clock);
    endtask

    task automatic pulse_reset(input int dly);
        #(dly);
        reset_n = 1'b0;
        #1;
        check("rst_req",   {31'h0, imem_req},   32'h0);
        check("rst_addr",  imem_addr,           RST_PC);
        check("rst_instr", ifid_instr,          32'h0);
        check("rst_pc4",   ifid_pc4,            32'h0);
        check("rst_valid", {31'h0, ifid_valid}, 32'h0);
        model_reset();
        stall = 1'b0; pc_src = 1'b0; jump = 1'b0; imem_ack = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFF0 | {28'h0, 4'($urandom)};
            1:       return $urandom;
            default: return {20'h0, 12'($urandom)};
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        stall = 1'b0; pc_src = 1'b0; jump = 1'b0; imem_ack = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clock);
        pulse_reset(1);

        // Zero-wait memory: addresses 0,4,8 and pc4 4,8,12 back to back.
        step(0, 0, 0, 0, 0, 1);
        check("zw_addr0", imem_addr, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        check("zw_addr4", imem_addr, 32'h4);
        check("zw_pc4_4", ifid_pc4, 32'h4);
        step(0, 0, 0, 0, 0, 1);
        check("zw_addr8", imem_addr, 32'h8);
        check("zw_pc4_8", ifid_pc4, 32'h8);
        step(0, 0, 0, 0, 0, 1);
        check("zw_pc4_12", ifid_pc4, 32'hC);
        check("zw_instr8", ifid_instr, mem_word(32'h8));

        // Ack at address 8 under a three-cycle stall.
        pulse_reset(2);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("hold_req", {31'h0, imem_req}, 32'h0);
        check("hold_instr", ifid_instr, mem_word(32'h4));
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check("hold_frozen", ifid_pc4, 32'h8);
        step(0, 0, 0, 0, 0, 0);
        check("hold_release_instr", ifid_instr, mem_word(32'h8));
        check("hold_next_addr", imem_addr, 32'hC);

        // Taken branch with ack: one bubble then fetch at 0x40.
        step(0, 1, 32'h40, 0, 0, 1);
        check("br_bubble", {31'h0, ifid_valid}, 32'h0);
        check("br_addr", imem_addr, 32'h40);

        // Jump while the request is pending: address held, stale data dropped.
        step(0, 0, 0, 1, 32'h100, 0);
        check("drop_addr_held", imem_addr, 32'h40);
        step(0, 0, 0, 0, 0, 0);
        check("drop_addr_held2", imem_addr, 32'h40);
        step(0, 0, 0, 0, 0, 1);
        check("drop_no_data", {31'h0, ifid_valid}, 32'h0);
        check("drop_addr_jump", imem_addr, 32'h100);

        // Branch and jump together: suppressed by stall, then branch wins.
        step(1, 1, 32'h200, 1, 32'h300, 0);
        check("both_stalled", imem_addr, 32'h100);
        step(0, 1, 32'h200, 1, 32'h300, 1);
        check("both_branch_wins", imem_addr, 32'h200);

        // Wrap of pc+4 and unaligned target pass-through.
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 0, 1);
        check("wrap_pc4", ifid_pc4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1, 32'h0000_0103, 1);
        check("unaligned_addr", imem_addr, 32'h103);

        // Reset in the middle of DROP; the late ack in IDLE must be ignored.
        step(0, 0, 0, 1, 32'h500, 0);
        check("pre_rst_drop_req", {31'h0, imem_req}, 32'h1);
        pulse_reset(3);
        step(0, 0, 0, 0, 0, 1);
        check("post_rst_addr", imem_addr, RST_PC);
        check("post_rst_req", {31'h0, imem_req}, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 249) pulse_reset($urandom_range(1, 3));
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, pick_target(),
                 $urandom_range(0, 9) < 2, pick_target(), $urandom_range(0, 9) < 6);
        end
        compare_model();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clock  in  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall  in  1  ID-stage hazard stall; holds IF/ID and PC.
REQ-005 SHALL have port pc_src  in  1  branch taken, resolved in ID.
REQ-006 SHALL have port branch_target  in  32  branch destination.
REQ-007 SHALL have port jump  in  1  jump decoded in ID.
REQ-008 SHALL have port jump_target  in  32  jump destination.
REQ-009 SHALL have port imem_req  out  1  instruction-memory request.
REQ-010 SHALL have port imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
REQ-011 SHALL have port imem_rdata  in  32  instruction word; valid with imem_ack.
REQ-012 SHALL have port imem_ack  in  1  completes the current request; ignored when imem_req=0.
REQ-013 SHALL have ports ifid_instr  out  32, ifid_pc4  out  32, ifid_valid  out  1: the registered IF/ID outputs.

Function
REQ-014 SHALL implement states IDLE, REQ, DROP, HOLD; imem_req=1 in REQ and DROP only.
REQ-015 SHALL form redirect = (pc_src|jump) & ~stall; when pc_src and jump are both set, SHALL use branch_target.
REQ-016 IDLE SHALL go to REQ unconditionally after one cycle.
REQ-017 REQ, ack, no redirect, ~stall: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay REQ.
REQ-018 REQ, ack, no redirect, stall: capture imem_rdata in hold buffer; IF/ID unchanged; go HOLD.
REQ-019 REQ, ack, redirect: discard data; pc <= target; IF/ID <= bubble (instr 0, valid 0); stay REQ.
REQ-020 REQ, no ack, redirect: save target; IF/ID <= bubble; go DROP; imem_addr SHALL stay unchanged.
REQ-021 REQ, no ack, no redirect: IF/ID <= bubble if ~stall, else unchanged.
REQ-022 DROP: a new redirect SHALL overwrite the saved target; on ack, discard data, pc <= saved target, go REQ; IF/ID SHALL get a bubble each cycle ~stall.
REQ-023 HOLD, ~stall, no redirect: IF/ID <= {buffer, pc+4, 1}; pc <= pc+4; go REQ.
REQ-024 HOLD, redirect: discard buffer; pc <= target; IF/ID <= bubble; go REQ.
REQ-025 HOLD, stall: all state SHALL be held.
REQ-026 Latency: ack in cycle N SHALL be visible on ifid_* in cycle N+1; with zero-wait memory, throughput SHALL be one instruction per cycle.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0); bits [1:0] of the targets SHALL pass through unchecked.

Reset
REQ-028 While reset_n=0: state=IDLE, pc=RESET_PC, imem_req=0, ifid_instr=0, ifid_pc4=0, ifid_valid=0, hold buffer and saved target=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; a late ack in IDLE SHALL be ignored.

Structure
REQ-030 The state encoding, the NOP constant 32'h0 and the RESET_PC default SHALL live in the shared pipeline package.
REQ-031 SHALL instantiate the existing adder #(32) for pc+4 and mux #(32) for target select; no new sub-module.

Verification
REQ-032 Zero-wait ack every cycle from reset: imem_addr 0,4,8; ifid_pc4 4,8,12 on consecutive cycles.
REQ-033 Ack at addr 8 while stall=1 for 3 cycles: HOLD, imem_req=0, IF/ID frozen; after release ifid_instr=word@8, next addr 12.
REQ-034 pc_src=1, branch_target=0x40 with ack: one bubble; next imem_addr=0x40.
REQ-035 jump=1 (target 0x100) while req pending 2 cycles: addr held, DROP, stale data dropped, then addr=0x100.
REQ-036 pc_src=1 and jump=1 with stall=1: no redirect; once stall=0, branch_target wins.
REQ-037 reset_n pulsed low mid-DROP: outputs at reset values immediately; first request at RESET_PC after IDLE.
